// File: rtl/cp0_pkg.sv
// CP0 register map, field positions and exception codes shared by the
// exception sequencer and its register file.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HANDLER = 1'b1
  } exc_state_e;

  function automatic logic [31:0] align_pc(
    input logic [31:0] pc
  );
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_regfile.sv
// CP0 storage (SR mask/enable, Cause, EPC, PRId), mtc0 write priority
// and the combinational mfc0 read mux. EXL lives in the sequencer FSM.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h2017_1207
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic        exc_take,
  input  logic [4:0]  exc_code,
  input  logic        exc_bd,
  input  logic [31:0] exc_epc,
  input  logic [5:0]  hw_int,
  input  logic        exl,
  output logic [31:0] rdata,
  output logic [5:0]  im,
  output logic        ie,
  output logic [31:0] epc
);

  logic [5:0]  im_q;
  logic        ie_q;
  logic        bd_q;
  logic [5:0]  ip_q;
  logic [4:0]  code_q;
  logic [31:0] epc_q;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q   <= '0;
      ie_q   <= 1'b0;
      bd_q   <= 1'b0;
      ip_q   <= '0;
      code_q <= '0;
      epc_q  <= '0;
    end else begin
      ip_q <= hw_int;
      // an exception entry swallows a same-cycle mtc0
      if (exc_take) begin
        code_q <= exc_code;
        bd_q   <= exc_bd;
        epc_q  <= align_pc(exc_epc);
      end else if (we) begin
        if (addr == CP0_SR) begin
          im_q <= wdata[SR_IM_HI:SR_IM_LO];
          ie_q <= wdata[SR_IE];
        end
        if (addr == CP0_EPC) begin
          epc_q <= align_pc(wdata);
        end
      end
    end
  end

  assign sr_val = {16'b0, im_q, 8'b0, exl, ie_q};

  assign cause_val = {bd_q, 15'b0, ip_q, 3'b0,
                      code_q, 2'b0};

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (addr == CP0_SR):    rdata = sr_val;
      (addr == CP0_CAUSE): rdata = cause_val;
      (addr == CP0_EPC):   rdata = epc_q;
      (addr == CP0_PRID):  rdata = PRID_VAL;
      default:             rdata = '0;
    endcase
  end

  assign im  = im_q;
  assign ie  = ie_q;
  assign epc = epc_q;

endmodule

// File: rtl/exc_redirect_ctrl.sv
// Exception/interrupt sequencer: RUN/HANDLER FSM and fetch redirects.
// Define EXC_BD_EN to record Cause.BD and rewind EPC over a branch.
module exc_redirect_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL   = 32'h2017_1207
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  HWInt,
  input  logic [4:0]  ExcCode_in,
  input  logic [31:0] ExcPC,
  input  logic        BD_in,
  input  logic        eret,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        IntReq,
  output logic        EXLClr,
  output logic [31:0] EPC,
  output logic        Flush
);

  exc_state_e  state;
  logic        exl;
  logic [5:0]  im;
  logic        ie;
  logic        int_hit;
  logic        exc_hit;
  logic [4:0]  exc_code;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic [31:0] unused_handler;

  assign unused_handler = HANDLER_PC;

  assign exl     = (state == ST_HANDLER);
  assign int_hit = ie & (|(HWInt & im));
  assign exc_hit = |ExcCode_in;
  assign IntReq  = ~exl & (int_hit | exc_hit);
  assign EXLClr  = eret;
  assign Flush   = IntReq | EXLClr;

  assign exc_code = int_hit ? EXC_INT : ExcCode_in;

`ifdef EXC_BD_EN
  assign exc_bd  = BD_in;
  assign exc_epc = BD_in ? (ExcPC - 32'd4) : ExcPC;
`else
  logic unused_bd;
  assign unused_bd = BD_in;
  assign exc_bd    = 1'b0;
  assign exc_epc   = ExcPC;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else if (IntReq) begin
      state <= ST_HANDLER;
    end else if (eret) begin
      state <= ST_RUN;
    end else if (we && addr == CP0_SR) begin
      state <= wdata[SR_EXL] ? ST_HANDLER : ST_RUN;
    end
  end

  cp0_regfile #(
    .PRID_VAL (PRID_VAL)
  ) u_regs (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .exc_take (IntReq),
    .exc_code (exc_code),
    .exc_bd   (exc_bd),
    .exc_epc  (exc_epc),
    .hw_int   (HWInt),
    .exl      (exl),
    .rdata    (rdata),
    .im       (im),
    .ie       (ie),
    .epc      (EPC)
  );

endmodule
